ram_responder: RTL and testbench
================================

RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 Parameter ADDR_BITS, default 10, word-address width; array depth 2**ADDR_BITS x 32 bit.
REQ-002 Parameter LATENCY, default 2, edges from request capture to done; legal range 1..15.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 ram_ctrl_from_mobo  input  32  bit0 read request, bit1 write request, bits 31:2 ignored.
REQ-006 ram_ctrl_to_mobo  output  32  bit0 done, bit1 address error, bits 31:2 driven 0.
REQ-007 addr  input  32  word address of request.
REQ-008 data_from_mobo  input  32  write data.
REQ-009 data_to_mobo  output  32  read data, valid while done=1.
REQ-010 busy  output  1  high in BUSY and DONE states.
REQ-011 txn_count  output  16  count of completed transactions.

Function
REQ-012 FSM SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-013 IDLE: at an edge with bit0 or bit1 of ram_ctrl_from_mobo high, capture op, addr, data_from_mobo into internal registers, load latency counter, go BUSY.
REQ-014 Simultaneous read and write request SHALL be treated as a write.
REQ-015 Inputs SHALL be ignored outside the capture edge; changes to addr/data during BUSY/DONE have no effect.
REQ-016 BUSY: counter decrements each edge; done rises exactly LATENCY edges after the capture edge, state becomes DONE on that edge.
REQ-017 Write commit: array word written on the edge done rises, only if no address error.
REQ-018 Read: data_to_mobo loaded on the edge done rises with the array word at captured address; held stable through DONE.
REQ-019 Address error: captured addr[31:ADDR_BITS] non-zero -> bit1 asserted together with done, no array write, data_to_mobo = 0.
REQ-020 Four-phase handshake: DONE holds done (and error) high until an edge samples bits1:0 both low; on that edge done and error clear, state becomes IDLE.
REQ-021 A request held high into IDLE after DONE SHALL NOT be recaptured; capture requires IDLE, so minimum one IDLE edge between transactions.
REQ-022 txn_count increments by 1 on each edge done rises (errors included), wraps 0xFFFF -> 0x0000.
REQ-023 Write-then-read of same address SHALL return the written value.
REQ-024 data_to_mobo SHALL keep its last value in IDLE and after writes (writes do not modify it).

Reset
REQ-025 rst high: state IDLE, counter 0, ram_ctrl_to_mobo 0, data_to_mobo 0, busy 0, txn_count 0, immediately and asynchronously.
REQ-026 Reset mid-transaction SHALL abort it: no array write after rst assertion, no done pulse, no txn_count change.
REQ-027 Memory array contents SHALL NOT be cleared by reset; uninitialised words read as X in simulation.
REQ-028 First capture possible on the first rising edge after rst deasserts.

Verification
REQ-029 Write 0xDEADBEEF to addr 5, LATENCY=2 -> done high exactly 2 edges after capture, error 0, txn_count 1; drop request -> done low next edge.
REQ-030 Read addr 5 after REQ-029 -> data_to_mobo 0xDEADBEEF with done, stable until request dropped; txn_count 2.
REQ-031 Read and write requested together at addr 7, data 0x12345678 -> treated as write; subsequent read of addr 7 returns 0x12345678.
REQ-032 Write to addr 0x400 (ADDR_BITS=10) -> done and error both high, data_to_mobo 0, read of addr 0 unchanged.
REQ-033 Assert rst one edge after capturing write 0xA5A5A5A5 to addr 3 -> done never rises, txn_count 0, addr 3 retains prior value.
REQ-034 Hold request high across DONE then 3 IDLE edges -> exactly one transaction, txn_count +1; preload 0xFFFF and complete one -> txn_count 0x0000.

Source files
------------

// File: rtl/ram_responder.sv
// Single-port word RAM answering a four-phase request/done handshake from the motherboard side.
// Latency: done rises LATENCY rising edges after the capture edge and stays high until the request drops.
// Backpressure: no new request is captured until done has been released and one IDLE edge has passed.
module ram_responder #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ram_ctrl_from_mobo,
    output logic [31:0] ram_ctrl_to_mobo,
    input  logic [31:0] addr,
    input  logic [31:0] data_from_mobo,
    output logic [31:0] data_to_mobo,
    output logic        busy,
    output logic [15:0] txn_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [3:0]             lat_cnt;
    logic [3:0]             lat_cnt_nxt;

    // Request captured on the IDLE edge; nothing else on the inputs is looked at afterwards.
    logic                   op_wr;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [31:0]            wdata_q;
    logic                   addr_err_q;

    logic                   done_q;
    logic                   err_q;
    logic [31:0]            rdata_q;
    logic [15:0]            txn_q;

    logic [31:0]            mem [0:(1<<ADDR_BITS)-1];

    logic                   req_rd;
    logic                   req_wr;
    logic                   req_any;
    logic                   capture;
    logic                   finish;
    logic                   release_hs;
    logic                   unused_ctrl_bits;

    assign req_rd           = ram_ctrl_from_mobo[0];
    assign req_wr           = ram_ctrl_from_mobo[1];
    assign req_any          = req_rd | req_wr;
    assign unused_ctrl_bits = |ram_ctrl_from_mobo[31:2];

    // State and latency counter register; reset drops any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            lat_cnt <= 4'd0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_cnt_nxt;
        end
    end

    // Next-state logic plus the one-edge strobes that steer the datapath.
    always_comb begin
        state_nxt   = state;
        lat_cnt_nxt = lat_cnt;
        capture     = 1'b0;
        finish      = 1'b0;
        release_hs  = 1'b0;
        case (state)
            IDLE: begin
                if (req_any) begin
                    capture     = 1'b1;
                    lat_cnt_nxt = 4'(LATENCY);
                    state_nxt   = BUSY;
                end
            end
            BUSY: begin
                lat_cnt_nxt = lat_cnt - 4'd1;
                if (lat_cnt == 4'd1) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // Done is held until the requester has dropped both request bits.
                if (!req_any) begin
                    release_hs = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: begin
                state_nxt   = IDLE;
                lat_cnt_nxt = 4'd0;
            end
        endcase
    end

    // Request capture: a simultaneous read+write is taken as a write; the range check is done here once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_wr      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            addr_err_q <= 1'b0;
        end else if (capture) begin
            op_wr      <= req_wr;
            addr_q     <= addr[ADDR_BITS-1:0];
            wdata_q    <= data_from_mobo;
            addr_err_q <= |addr[31:ADDR_BITS];
        end
    end

    // Completion flags, read data and transaction counter; read data is untouched by writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            txn_q   <= 16'd0;
        end else if (finish) begin
            done_q <= 1'b1;
            err_q  <= addr_err_q;
            txn_q  <= txn_q + 16'd1;
            if (addr_err_q) begin
                rdata_q <= 32'd0;
            end else if (!op_wr) begin
                rdata_q <= mem[addr_q];
            end
        end else if (release_hs) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end
    end

    // Array write commits on the done edge; the array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (finish && op_wr && !addr_err_q) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign ram_ctrl_to_mobo = {30'd0, err_q, done_q};
    assign data_to_mobo     = rdata_q;
    assign busy             = (state != IDLE);
    assign txn_count        = txn_q;

endmodule

// File: tb/tb_ram_responder.sv
// Randomised and directed bench for ram_responder with a queue-based scoreboard.
// Latency: checks done arrives LATENCY edges after capture.
// Backpressure: exercises holding the request across DONE and reset aborts.
module tb_ram_responder;

    localparam int ADDR_BITS = 10;
    localparam int LATENCY   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ram_ctrl_from_mobo;
    logic [31:0] ram_ctrl_to_mobo;
    logic [31:0] addr;
    logic [31:0] data_from_mobo;
    logic [31:0] data_to_mobo;
    logic        busy;
    logic [15:0] txn_count;

    ram_responder #(.ADDR_BITS(ADDR_BITS), .LATENCY(LATENCY)) dut (
        .clk                (clk),
        .rst                (rst),
        .ram_ctrl_from_mobo (ram_ctrl_from_mobo),
        .ram_ctrl_to_mobo   (ram_ctrl_to_mobo),
        .addr               (addr),
        .data_from_mobo     (data_from_mobo),
        .data_to_mobo       (data_to_mobo),
        .busy               (busy),
        .txn_count          (txn_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic        chk_data;
        logic [31:0] data;
        logic [15:0] cnt;
    } exp_t;

    exp_t            sbq[$];
    logic [31:0]     mem_m [int];
    logic [31:0]     m_rdata;
    logic            m_known;
    logic [15:0]     m_cnt;
    int              tests;
    int              fails;
    logic            prev_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what a completed request should look like, from the request alone.
    task automatic issue(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        bit   err;
        int   idx;
        err = (a >> ADDR_BITS) != 0;
        idx = int'(a % (1 << ADDR_BITS));
        m_cnt = m_cnt + 16'd1;
        if (err) begin
            m_rdata = 32'd0;
            m_known = 1'b1;
        end else if (wr) begin
            mem_m[idx] = d;
        end else if (rd) begin
            if (mem_m.exists(idx)) begin
                m_rdata = mem_m[idx];
                m_known = 1'b1;
            end else begin
                m_known = 1'b0;
            end
        end
        e.err      = err;
        e.chk_data = m_known;
        e.data     = m_rdata;
        e.cnt      = m_cnt;
        sbq.push_back(e);
    endtask

    // One full four-phase transaction, holding the request for 'hold' extra cycles in DONE.
    task automatic do_txn(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input int hold);
        int edges;
        bit got;
        @(negedge clk);
        ram_ctrl_from_mobo = {30'd0, wr, rd};
        addr               = a;
        data_from_mobo     = d;
        issue(rd, wr, a, d);
        @(posedge clk);
        #1;
        chk("busy_after_capture", {31'd0, busy}, 32'd1);
        addr           = $urandom;
        data_from_mobo = $urandom;
        edges = 0;
        got   = 1'b0;
        while (!got && edges < 40) begin
            @(posedge clk);
            edges++;
            #1;
            if (ram_ctrl_to_mobo[0]) got = 1'b1;
        end
        chk("done_latency", 32'(edges), 32'(LATENCY));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("done_held", {31'd0, ram_ctrl_to_mobo[0]}, 32'd1);
            chk("cnt_held", {16'd0, txn_count}, {16'd0, m_cnt});
        end
        @(negedge clk);
        ram_ctrl_from_mobo = 32'd0;
        @(posedge clk);
        #1;
        chk("done_drop", ram_ctrl_to_mobo, 32'd0);
        chk("busy_drop", {31'd0, busy}, 32'd0);
    endtask

    // Monitor: every rising done is matched against the oldest expected completion.
    always @(negedge clk) begin
        if (rst) begin
            prev_done <= 1'b0;
        end else begin
            if (ram_ctrl_to_mobo[0] && !prev_done) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("err_bit", {31'd0, ram_ctrl_to_mobo[1]}, {31'd0, e.err});
                    chk("upper_ctrl_zero", {2'd0, ram_ctrl_to_mobo[31:2]}, 32'd0);
                    chk("txn_count", {16'd0, txn_count}, {16'd0, e.cnt});
                    if (e.chk_data) chk("read_data", data_to_mobo, e.data);
                end
            end
            prev_done <= ram_ctrl_to_mobo[0];
        end
    end

    initial begin
        #100us;
        $display("FAIL timeout: simulation did not complete, fails=%0d", fails);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v3;
        tests   = 0;
        fails   = 0;
        m_cnt   = 16'd0;
        m_rdata = 32'd0;
        m_known = 1'b1;
        rst                = 1'b1;
        ram_ctrl_from_mobo = 32'd0;
        addr               = 32'd0;
        data_from_mobo     = 32'd0;
        #1;
        chk("rst_ctrl", ram_ctrl_to_mobo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cnt", {16'd0, txn_count}, 32'd0);
        chk("rst_data", data_to_mobo, 32'd0);
        #23;
        @(negedge clk);
        rst = 1'b0;

        // Directed scenarios.
        do_txn(0, 1, 32'd5, 32'hDEADBEEF, 0);
        do_txn(1, 0, 32'd5, 32'd0, 2);
        do_txn(1, 1, 32'd7, 32'h12345678, 0);
        do_txn(1, 0, 32'd7, 32'd0, 0);
        do_txn(0, 1, 32'd0, 32'h0BADF00D, 0);
        do_txn(0, 1, 32'h400, 32'hFFFF_FFFF, 1);
        do_txn(1, 0, 32'd0, 32'd0, 0);
        do_txn(1, 0, 32'h8000_0003, 32'd0, 0);

        // Reset during a write to address 3 must leave the old word in place.
        v3 = $urandom;
        do_txn(0, 1, 32'd3, v3, 0);
        @(negedge clk);
        ram_ctrl_from_mobo = 32'd2;
        addr               = 32'd3;
        data_from_mobo     = 32'hA5A5A5A5;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_ctrl", ram_ctrl_to_mobo, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_cnt", {16'd0, txn_count}, 32'd0);
        chk("abort_data", data_to_mobo, 32'd0);
        m_cnt   = 16'd0;
        m_rdata = 32'd0;
        m_known = 1'b1;
        ram_ctrl_from_mobo = 32'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_done", {31'd0, ram_ctrl_to_mobo[0]}, 32'd0);
        end
        rst = 1'b0;
        do_txn(1, 0, 32'd3, 32'd0, 0);

        // Counter wrap, with the request held across DONE, then idle edges.
        @(negedge clk);
        force dut.txn_q = 16'hFFFF;
        #1;
        release dut.txn_q;
        m_cnt = 16'hFFFF;
        do_txn(1, 0, 32'd5, 32'd0, 3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_cnt", {16'd0, txn_count}, 32'd0);
            chk("idle_done", {31'd0, ram_ctrl_to_mobo[0]}, 32'd0);
        end

        // Randomised traffic over a small address window plus occasional bad addresses.
        for (int n = 0; n < 40; n++) begin
            bit          rd;
            bit          wr;
            logic [31:0] a;
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if (!rd && !wr) rd = 1'b1;
            if ($urandom_range(0, 9) == 0) a = 32'h400 | $urandom;
            else a = 32'($urandom_range(0, 15));
            do_txn(rd, wr, a, $urandom, int'($urandom_range(0, 3)));
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
